// File: rtl/seg_pkg.sv
// Shared types and constants for the six-digit multiplexed display scanner.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

  localparam logic [NUM_DIGITS-1:0] SEL_OFF = 6'b111111;

  typedef enum logic [1:0] {
    S_OFF,
    S_DRIVE,
    S_GUARD
  } state_t;

  // One displayable frame: digits, decimal points and blanking enable
  typedef struct packed {
    logic                  lzb;
    logic [NUM_DIGITS-1:0] dp;
    logic [BCD_W-1:0]      bcd;
  } frame_t;

  // Active-low one-hot select for a digit index
  function automatic logic [NUM_DIGITS-1:0] digit_sel(input logic [DIGIT_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_lzb.sv
// Leading-zero blank mask: a digit is blanked while it and every higher digit
// read zero with no decimal point; digit 0 always stays lit.
module seg_lzb
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0]      bcd,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic                  lzb,
  output logic [NUM_DIGITS-1:0] blank_c
);

  logic lead;

  always_comb begin
    lead    = 1'b1;
    blank_c = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead       = lead && (bcd[4*i +: 4] == 4'd0) && !dp[i];
      blank_c[i] = lzb && lead;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit display scanner: holds one frame, cycles digits with a guard gap,
// and swaps in new data only at frame boundaries.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BCD_W-1:0]      bcd,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  lzb,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [3:0]            code,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

  state_t               state, nxt_state;
  logic [DIGIT_W-1:0]   digit, nxt_digit, digit_inc;
  logic [CNT_W-1:0]     cnt, nxt_cnt;
  frame_t               disp, pend, offer, disp_nxt;
  logic                 pend_full;
  logic                 accept, frame_end, boundary, commit, nxt_drive;
  logic [NUM_DIGITS-1:0] blank_c;

  assign offer     = {lzb, dp_in, bcd};
  assign accept    = in_valid && in_ready;
  assign frame_end = (state == S_DRIVE) && (digit == LAST_DIGIT) && (cnt == DRIVE_LAST);
  assign boundary  = (state == S_OFF) || frame_end;
  assign commit    = boundary && (accept || pend_full);
  // A same-edge offer at a boundary bypasses the pending register
  assign disp_nxt  = commit ? (accept ? offer : pend) : disp;
  assign digit_inc = (digit == LAST_DIGIT) ? '0 : digit + DIGIT_W'(1);
  assign nxt_drive = (nxt_state == S_DRIVE);

  // Blank mask follows the frame that will be on screen next cycle
  seg_lzb u_lzb (
    .bcd     (disp_nxt.bcd),
    .dp      (disp_nxt.dp),
    .lzb     (disp_nxt.lzb),
    .blank_c (blank_c)
  );

  always_comb begin
    nxt_state = state;
    nxt_digit = digit;
    nxt_cnt   = cnt;
    case (state)
      S_OFF: begin
        if (commit) begin
          nxt_state = S_DRIVE;
          nxt_digit = '0;
          nxt_cnt   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          nxt_cnt = '0;
          if (GUARD == 0) begin
            nxt_digit = digit_inc;
          end else begin
            nxt_state = S_GUARD;
          end
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      S_GUARD: begin
        if (cnt == GUARD_LAST) begin
          nxt_state = S_DRIVE;
          nxt_digit = digit_inc;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      default: nxt_state = S_OFF;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_OFF;
      digit      <= '0;
      cnt        <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      in_ready   <= 1'b1;
      sel        <= SEL_OFF;
      code       <= 4'd0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt_state;
      digit <= nxt_digit;
      cnt   <= nxt_cnt;
      disp  <= disp_nxt;

      if (accept && !boundary) begin
        pend      <= offer;
        pend_full <= 1'b1;
        in_ready  <= 1'b0;
      end else if (commit) begin
        pend_full <= 1'b0;
        in_ready  <= 1'b1;
      end

      sel        <= (nxt_drive && !blank_c[nxt_digit]) ? digit_sel(nxt_digit) : SEL_OFF;
      code       <= nxt_drive ? disp_nxt.bcd[{nxt_digit, 2'b00} +: 4] : 4'd0;
      dp         <= nxt_drive && disp_nxt.dp[nxt_digit];
      frame_done <= nxt_drive && (nxt_digit == LAST_DIGIT) && (nxt_cnt == DRIVE_LAST);
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan with SCAN_DIV=4, GUARD=2 (36-cycle frame).
module tb_seg_scan;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned GUARD    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] bcd;
  logic [5:0]  dp_in;
  logic        lzb;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  sel;
  logic [3:0]  code;
  logic        dp;
  logic        frame_done;

  typedef struct {
    logic [5:0] sel;
    logic [3:0] code;
    logic       dp;
    int         gap;   // cycles since previous lit cycle, 0 = unchecked
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   fd_count    = 0;
  bit   mon_en      = 1'b0;

  seg_scan #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd        (bcd),
    .dp_in      (dp_in),
    .lzb        (lzb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .code       (code),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_digit(input int d, input logic [3:0] c, input logic p, input int g);
    logic [5:0] s;
    s = 6'b000001 << d;
    s = ~s;
    for (int k = 0; k < int'(SCAN_DIV); k++)
      q.push_back('{sel: s, code: c, dp: p, gap: (k == 0) ? g : 1});
  endtask

  task automatic push_123456(input int g);
    push_digit(0, 4'd6, 1'b0, g);
    push_digit(1, 4'd5, 1'b0, 3);
    push_digit(2, 4'd4, 1'b0, 3);
    push_digit(3, 4'd3, 1'b0, 3);
    push_digit(4, 4'd2, 1'b0, 3);
    push_digit(5, 4'd1, 1'b0, 3);
  endtask

  // Present an offer and hold it until the edge that transfers it
  task automatic offer(input logic [23:0] b, input logic [5:0] d, input logic l, output int edge_cyc);
    bcd = b; dp_in = d; lzb = l; in_valid = 1'b1;
    edge_cyc = -1;
    for (int n = 0; n < 200; n++) begin
      if (in_ready === 1'b1) begin
        tick;
        in_valid = 1'b0;
        edge_cyc = cyc;
        return;
      end
      tick;
    end
    in_valid = 1'b0;
    chk("offer_timeout", 32'(in_ready), 32'd1);
  endtask

  // Pops one expected entry per lit cycle; tracks frame_done spacing
  initial begin : monitor
    exp_t e;
    int   since;
    int   last_fd;
    bit   fd_valid;
    since = 0; last_fd = 0; fd_valid = 1'b0;
    forever begin
      @(negedge clk);
      since++;
      if (reset === 1'b1) fd_valid = 1'b0;
      if (mon_en && sel !== 6'b111111) begin
        if (q.size() == 0) begin
          chk("unexpected_drive", 32'(sel), 32'h3f);
        end else begin
          e = q.pop_front();
          chk("scan_out{sel,code,dp}", 32'({sel, code, dp}), 32'({e.sel, e.code, e.dp}));
          if (e.gap != 0) chk("slot_gap", 32'(since), 32'(e.gap));
        end
        since = 0;
      end
      if (mon_en && frame_done === 1'b1) begin
        fd_count++;
        if (fd_valid) chk("frame_period", 32'(cyc - last_fd), 32'd36);
        last_fd  = cyc;
        fd_valid = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int c0, t;
    reset = 1'b1; in_valid = 1'b0; bcd = '0; dp_in = '0; lzb = 1'b0;
    tick; tick;
    reset = 1'b0;
    mon_en = 1'b1;
    chk("rst_sel", 32'(sel), 32'h3f);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // No offer: display must stay dark
    repeat (1000) tick;
    chk("idle_sel", 32'(sel), 32'h3f);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_frame_done_count", 32'(fd_count), 32'd0);

    // Frames 0,1: 123456; frame 2: 111111; frame 3: 000042 lzb;
    // frames 4,5: 000042 lzb with dp on digit 3 (frame 5 cut by reset)
    push_123456(0);
    push_123456(3);
    for (int d = 0; d < 6; d++) push_digit(d, 4'd1, 1'b0, 3);
    push_digit(0, 4'd2, 1'b0, 3);
    push_digit(1, 4'd4, 1'b0, 3);
    push_digit(0, 4'd2, 1'b0, 27);
    push_digit(1, 4'd4, 1'b0, 3);
    push_digit(2, 4'd0, 1'b0, 3);
    push_digit(3, 4'd0, 1'b1, 3);
    push_digit(0, 4'd2, 1'b0, 15);
    push_digit(1, 4'd4, 1'b0, 3);
    push_digit(2, 4'd0, 1'b0, 3);
    q.push_back('{sel: 6'b110111, code: 4'd0, dp: 1'b1, gap: 3});
    q.push_back('{sel: 6'b110111, code: 4'd0, dp: 1'b1, gap: 1});

    offer(24'h123456, 6'b000000, 1'b0, c0);
    chk("first_commit_in_ready", 32'(in_ready), 32'd1);

    while (cyc < c0 + 48) tick;
    offer(24'h111111, 6'b000000, 1'b0, t);
    chk("midframe_transfer_edge", 32'(t - c0), 32'd49);
    chk("pending_in_ready", 32'(in_ready), 32'd0);

    offer(24'h000042, 6'b000000, 1'b1, t);
    chk("held_offer_transfer_edge", 32'(t - c0), 32'd71);
    chk("held_pending_in_ready", 32'(in_ready), 32'd0);

    while (cyc < c0 + 109) tick;
    offer(24'h000042, 6'b001000, 1'b1, t);
    chk("dp_offer_transfer_edge", 32'(t - c0), 32'd110);

    // Reset in the middle of digit 3, with a competing offer
    while (cyc < c0 + 199) tick;
    chk("frames_before_reset", 32'(fd_count), 32'd5);
    reset = 1'b1; in_valid = 1'b1; bcd = 24'h999999; dp_in = '0; lzb = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("midscan_rst_sel", 32'(sel), 32'h3f);
    chk("midscan_rst_code", 32'(code), 32'd0);
    chk("midscan_rst_dp", 32'(dp), 32'd0);
    chk("midscan_rst_frame_done", 32'(frame_done), 32'd0);
    chk("midscan_rst_in_ready", 32'(in_ready), 32'd1);
    chk("queue_drained_at_reset", 32'(q.size()), 32'd0);
    reset = 1'b0;

    repeat (50) tick;
    chk("post_reset_dark_sel", 32'(sel), 32'h3f);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Fresh offer restarts the scan from digit 0
    push_123456(0);
    offer(24'h123456, 6'b000000, 1'b0, c0);
    for (int n = 0; n < 100 && q.size() != 0; n++) tick;
    chk("restart_queue_drained", 32'(q.size()), 32'd0);
    chk("restart_frame_done_count", 32'(fd_count), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each digit is driven (1 kHz digit rate at 50 MHz).
REQ-002 Parameter GUARD, default 50, clk cycles all digits are off between digits (anti-ghosting).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bcd  input  24  six BCD digits; bcd[3:0] = digit 0 (rightmost).
REQ-006 dp_in  input  6  decimal point per digit, bit i = digit i.
REQ-007 lzb  input  1  leading-zero blanking enable, sampled with bcd.
REQ-008 in_valid  input  1  bcd/dp_in/lzb offered.
REQ-009 in_ready  output  1  block accepts an offer this cycle.
REQ-010 sel  output  6  active-low one-hot digit select to seg_decoder.
REQ-011 code  output  4  BCD code of the selected digit to seg_decoder.
REQ-012 dp  output  1  decimal point of the selected digit.
REQ-013 frame_done  output  1  one-cycle pulse when digit 5 finishes its drive period.

Function
REQ-014 A transfer occurs on a rising edge with in_valid=1 and in_ready=1; the triple is stored in a pending register.
REQ-015 in_ready = 1 when the pending register is empty; 0 from the transfer until the pending value is committed.
REQ-016 Pending value commits to the display register only at a frame boundary (frame_done cycle) or while state is OFF, so a frame never mixes old and new data.
REQ-017 States: OFF (sel=6'b111111, waits for first commit), DRIVE (one digit on for SCAN_DIV cycles), GUARD (sel all high for GUARD cycles).
REQ-018 OFF -> DRIVE digit 0 on the cycle after the first commit; DRIVE -> GUARD after SCAN_DIV cycles; GUARD -> DRIVE next digit after GUARD cycles.
REQ-019 Digit index increments 0..5 and wraps 5 -> 0; frame_done pulses on the last DRIVE cycle of digit 5.
REQ-020 In DRIVE, sel[i]=0 only for current digit i; code = display digit i; dp = display dp bit i.
REQ-021 In GUARD and OFF, code=4'd0, dp=0.
REQ-022 Leading-zero blanking: when lzb=1, digit i with value 0 and all higher digits 0 keeps sel[i]=1 for its DRIVE period; digit 0 is never blanked.
REQ-023 A digit whose dp bit is 1 is never blanked, nor any lower digit.
REQ-024 BCD values 10..15 pass to code unmodified; blanking treats only 4'd0 as zero.
REQ-025 Simultaneous transfer and frame boundary: the new value is stored and committed at that edge; in_ready stays 1.
REQ-026 Counters are sized $clog2(max(SCAN_DIV,GUARD)) bits; SCAN_DIV>=1, GUARD>=0; GUARD=0 skips GUARD state.

Reset
REQ-027 reset=1 at a rising edge: state OFF, digit index 0, counters 0, pending and display registers cleared, sel=6'b111111, code=0, dp=0, frame_done=0, in_ready=1.
REQ-028 reset asserted mid-scan or mid-transfer aborts immediately; any offer accepted in the same cycle is discarded.

Structure
REQ-029 Shared package seg_pkg holds state enumeration (OFF/DRIVE/GUARD), NUM_DIGITS=6, SEL_OFF=6'b111111.
REQ-030 One sub-module, seg_lzb, computes the 6-bit blank mask combinationally from display bcd, dp and lzb.
REQ-031 seg_scan instantiates directly upstream of seg_decoder: sel and code feed seg_decoder sel/data inputs.

Verification
REQ-032 Reset then no offer for 1000 cycles -> sel=6'b111111, in_ready=1, frame_done never pulses.
REQ-033 SCAN_DIV=4, GUARD=2, offer bcd=24'h123456 -> sel 111110 code 6 for 4 cycles, 2 cycles 111111, then 111101 code 5 ... digit 5 code 1; frame_done every 36 cycles.
REQ-034 lzb=1, bcd=24'h000042, dp_in=0 -> digits 5..2 keep sel high during their slots; digits 1,0 show 4,2; dp_in=6'b001000 -> digits 3..0 shown.
REQ-035 Offer 24'h111111 mid-frame -> in_ready=0 until frame_done; codes remain old until next digit 0 slot; second offer held off (in_valid high, no transfer) until commit.
REQ-036 Assert reset during digit 3 DRIVE -> next cycle sel=6'b111111, state OFF, in_ready=1; new offer restarts at digit 0.
